// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end constants and prefetch FSM state type
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } pfq_state_t;
endpackage

// File: rtl/pfq_fifo.sv
// rtl/pfq_fifo.sv - synchronous FIFO holding {instruction, address} prefetch entries
module pfq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head_data,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    // Popping an empty FIFO is a no-op rather than an underflow.
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_tail] <= i_push_data;
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
endmodule

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - sequential instruction prefetcher with redirect flush
module prefetch_queue import cpu_pkg::*; #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    input  logic               i_consume,
    output logic [INSTR_W-1:0] o_prefetch,
    output logic [ADDR_W-1:0]  o_prefetch_pc,
    output logic               o_prefetch_valid,
    output logic               o_mem_req,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_rdata
);
    localparam int                CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     LAST_CNT = CW'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(3);

    pfq_state_t                r_state;
    pfq_state_t                w_state_nxt;
    logic [ADDR_W-1:0]         r_fa;
    logic [ADDR_W-1:0]         w_fa_nxt;
    logic                      r_mem_req;
    logic                      w_req_nxt;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [ADDR_W-1:0]         w_addr_nxt;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_ack;
    logic                      w_stop;
    logic [CW-1:0]             w_count;
    logic                      w_empty;
    logic [INSTR_W+ADDR_W-1:0] w_head;

    assign w_ack = i_mem_ack && r_mem_req;
    assign w_pop = i_consume && !i_redirect && !w_empty;
    // Stop streaming when this write fills the last free slot.
    assign w_stop = (w_count == LAST_CNT) && !w_pop;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!i_redirect && (w_count != FULL_CNT)) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_redirect)          w_state_nxt = w_ack ? ST_IDLE : ST_DROP;
                else if (w_ack && w_stop) w_state_nxt = ST_IDLE;
            end
            ST_DROP: if (w_ack) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_nxt  = r_mem_req;
        w_addr_nxt = r_mem_addr;
        w_fa_nxt   = r_fa;
        w_push     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_redirect && (w_count != FULL_CNT)) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = r_fa;
                end
            end
            ST_WAIT: begin
                if (i_redirect) begin
                    if (w_ack) w_req_nxt = 1'b0;
                end else if (w_ack) begin
                    w_push   = 1'b1;
                    w_fa_nxt = r_mem_addr + STEP;
                    if (w_stop) w_req_nxt  = 1'b0;
                    else        w_addr_nxt = r_mem_addr + STEP;
                end
            end
            ST_DROP: if (w_ack) w_req_nxt = 1'b0;
            default: w_req_nxt = 1'b0;
        endcase
        if (i_redirect) w_fa_nxt = i_redirect_pc & ALIGN;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fa       <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_fa       <= w_fa_nxt;
            r_mem_req  <= w_req_nxt;
            r_mem_addr <= w_addr_nxt;
        end
    end

    pfq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data ({i_mem_rdata, r_mem_addr}),
        .i_pop       (w_pop),
        .i_flush     (i_redirect),
        .o_head_data (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign o_mem_req        = r_mem_req;
    assign o_mem_addr       = r_mem_addr;
    assign o_prefetch_valid = !w_empty;
    assign o_prefetch       = w_empty ? '0 : w_head[ADDR_W +: INSTR_W];
    assign o_prefetch_pc    = w_empty ? r_fa : w_head[ADDR_W-1:0];
endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - directed self-checking bench for prefetch_queue
module tb_prefetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        consume;
    logic [31:0] prefetch;
    logic [31:0] prefetch_pc;
    logic        prefetch_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int lat      = 0;
    int wait_cnt = 0;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        consume;
        logic        exp_req;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    prefetch_queue #(.DEPTH(4), .ADDR_W(32)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .i_consume        (consume),
        .o_prefetch       (prefetch),
        .o_prefetch_pc    (prefetch_pc),
        .o_prefetch_valid (prefetch_valid),
        .o_mem_req        (mem_req),
        .o_mem_addr       (mem_addr),
        .i_mem_ack        (mem_ack),
        .i_mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: ack after `lat` extra cycles of a pending request.
    assign mem_ack   = mem_req && (wait_cnt >= lat);
    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;
    always @(posedge clk) wait_cnt <= (!mem_req || mem_ack) ? 0 : wait_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string name, input logic req, input logic chk_a,
                            input logic [31:0] addr, input logic valid,
                            input logic [31:0] pc, input logic [31:0] data);
        chk({name, ".req"}, 32'(mem_req), 32'(req));
        if (chk_a) chk({name, ".addr"}, mem_addr, addr);
        chk({name, ".valid"}, 32'(prefetch_valid), 32'(valid));
        chk({name, ".pc"}, prefetch_pc, pc);
        chk({name, ".data"}, prefetch, data);
    endtask

    initial begin
        logic hold_ok;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        consume     = 1'b0;

        vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'h0};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0,  32'hA5A5_0000};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  32'hA5A5_0000};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd0,  32'hA5A5_0000};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd0,  32'hA5A5_0000};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd0,  32'hA5A5_0000};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 32'd4,  32'hA5A5_0004};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  32'hA5A5_0008};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 32'hA5A5_000C};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16, 32'hA5A5_0010};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd20, 32'hA5A5_0014};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd24, 32'hA5A5_0018};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd36, 1'b1, 32'd24, 32'hA5A5_0018};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 32'd24, 32'hA5A5_0018};

        step();
        chk_outs("reset", 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            consume     = vecs[i].consume;
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].chk_addr,
                     vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_data);
        end
        consume = 1'b0;

        // Slow memory; redirect while the request for 8 is pending.
        lat         = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        chk_outs("idle_redir", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        step();
        chk_outs("idle_redir_req", 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 40 && !(mem_req && mem_addr == 32'd8); k++) step();
        chk("reach_addr8", mem_addr, 32'd8);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk_outs("drop_enter", 1'b1, 1'b1, 32'd8, 1'b0, 32'h100, 32'd0);
        hold_ok = 1'b1;
        for (int k = 0; k < 20 && mem_req; k++) begin
            if (mem_addr != 32'd8) hold_ok = 1'b0;
            step();
        end
        chk("drop_hold", 32'(hold_ok), 32'd1);
        chk_outs("drop_done", 1'b0, 1'b0, 32'd0, 1'b0, 32'h100, 32'd0);
        step();
        chk_outs("drop_restart", 1'b1, 1'b1, 32'h100, 1'b0, 32'h100, 32'd0);
        for (int k = 0; k < 20 && !prefetch_valid; k++) step();
        chk_outs("drop_first", 1'b1, 1'b0, 32'd0, 1'b1, 32'h100, 32'hA5A5_0100);

        // Redirect coinciding with ack and consume.
        lat = 0;
        chk("b_pre_req", 32'(mem_req), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        consume     = 1'b1;
        step();
        redirect = 1'b0;
        consume  = 1'b0;
        chk_outs("ack_redir", 1'b0, 1'b0, 32'd0, 1'b0, 32'h200, 32'd0);
        step();
        chk_outs("ack_redir_req", 1'b1, 1'b1, 32'h200, 1'b0, 32'h200, 32'd0);
        step();
        chk_outs("ack_redir_fill", 1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'hA5A5_0200);

        // Asynchronous reset in the middle of a pending access.
        lat = 3;
        step();
        step();
        chk("c_pre_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("async_reset", 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_outs("post_reset", 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);

        // Address wrap past the top of memory; low bits of redirect_pc ignored.
        lat         = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        chk_outs("wrap_redir", 1'b0, 1'b0, 32'd0, 1'b0, 32'hFFFF_FFFC, 32'd0);
        step();
        chk_outs("wrap_req", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'd0);
        step();
        chk_outs("wrap_e0", 1'b1, 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
        step();
        consume = 1'b1;
        step();
        consume = 1'b0;
        chk_outs("wrap_e1", 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, 32'hA5A5_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Instruction prefetch unit upstream of the instruction fetch stage. Fetches sequential 32-bit words from instruction memory over a req/ack handshake and buffers them in a small FIFO. Presents the head word and its address to the fetch stage as `prefetch`. Flushes and restarts at a new address on a redirect from the fetch stage (taken branch or reset vector).

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `ADDR_W`, 32: address width.
- `clk`  in  1  main clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `redirect`  in  1  one-cycle pulse; flush and restart fetching at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  restart address; word-aligned, bits [1:0] ignored.
- `consume`  in  1  fetch stage takes the head entry this cycle.
- `prefetch`  out  32  head instruction word.
- `prefetch_pc`  out  ADDR_W  address of the head word.
- `prefetch_valid`  out  1  head entry present.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  request address; held stable while `mem_req` is high.
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.

## Operation
- Registers:
  - `fa`: next fetch address.
  - FIFO: data and address per entry, with head, tail and count.
  - FSM: IDLE, WAIT, DROP.
- At most one request is outstanding. `mem_req`, `mem_addr` and all outputs are registered.
- IDLE:
  - If `count < DEPTH` and no redirect: raise `mem_req` with `mem_addr = fa`, go to WAIT.
- WAIT (ack sampled while `mem_req` = 1):
  - Write {`mem_rdata`, `mem_addr`} at the tail.
  - Set `fa = mem_addr + 4`. Address arithmetic wraps modulo 2^ADDR_W.
  - If the post-update count is below `DEPTH`, keep `mem_req` high with `mem_addr = mem_addr + 4` and stay in WAIT (back-to-back requests).
  - Otherwise drop `mem_req` and go to IDLE.
- Redirect takes priority over consume and write:
  - Flush the FIFO (count = 0, head = tail) and set `fa = redirect_pc & ~3`.
  - From IDLE: stay in IDLE, no request this edge.
  - From WAIT: if ack is present on the same edge, discard the data, drop `mem_req` and go to IDLE. If no ack, go to DROP with `mem_req` and `mem_addr` held.
  - From DROP: update `fa` and stay in DROP.
- DROP:
  - `mem_req` stays high until ack.
  - On ack, discard the data, drop `mem_req` and go to IDLE.
- `consume` with count = 0 is ignored.
- `consume` and a write on the same edge leave count unchanged.
- A write never occurs with count = `DEPTH`; this follows from the issue rule above.
- When count = 0: `prefetch` = 0 and `prefetch_pc` = `fa`.

## Timing
- Reset values:
  - `fa` = 0, FSM = IDLE, count/head/tail = 0.
  - `mem_req` = 0, `mem_addr` = 0.
  - `prefetch` = 0, `prefetch_pc` = 0, `prefetch_valid` = 0.
- Reset mid-request abandons the outstanding access with no drain. Memory must tolerate `mem_req` dropping without an ack.
- After reset release: `mem_req` goes high one edge later, with `mem_addr` = 0.
- Fill latency with a zero-wait memory (ack in the same cycle as req): an entry written at edge N has `prefetch_valid` = 1 after edge N.
- Redirect sampled at edge N from IDLE (or WAIT with ack):
  - `mem_req` high after edge N+1.
  - First valid entry after edge N+2.
- Steady state with zero-wait memory: one word per cycle.
- `prefetch_valid` falls on the redirect edge itself.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_W = 32`.
  - Word stride `PC_STEP = 4`.
  - The FSM state enum `pfq_state_t`.
- Natural sub-module: `pfq_fifo`, a synchronous FIFO with `DEPTH` entries of width 32+ADDR_W, plus push, pop, flush and count.
- The FSM and `fa` live in the top level.

## Test plan
- Reset then zero-wait memory returning `mem_rdata` = `mem_addr` ^ 32'hA5A5_0000, with no consume:
  - Requests issued to 0, 4, 8, 12.
  - FIFO full with count 4; `mem_req` low after the 4th ack.
  - Head `prefetch` = 32'hA5A5_0000, `prefetch_pc` = 0.
- Full FIFO, then `consume` held for 6 cycles:
  - Heads appear in order 0, 4, 8, ...
  - Request to 16 issued the edge after the first pop.
  - No entry lost or duplicated.
- Memory with 3-cycle ack latency; `redirect` to 32'h100 one cycle after `mem_req` rises for address 8:
  - `mem_addr` stays 8 until ack.
  - Ack data discarded.
  - Next request is to 32'h100; first valid head has `prefetch_pc` = 32'h100.
- `redirect` to 32'h200 on the same edge as ack and consume:
  - FIFO empty the next cycle; ack data not written.
  - Next `mem_addr` = 32'h200.
- Async `reset` asserted mid-WAIT, between clock edges:
  - All outputs go to their reset values immediately.
  - After release, the first request is to address 0.
- `fa` = 32'hFFFF_FFFC, fill two entries:
  - Second entry has `prefetch_pc` = 0 (wrap).
